// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// Results are published only when the final chunk is added, so outputs never show partial sums.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_next;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             msb_cin;
  logic             last_chunk;

  assign chunk_a    = op_a[idx*CHUNK +: CHUNK];
  assign chunk_b    = op_b[idx*CHUNK +: CHUNK];
  assign {chunk_cout, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
  // Carry into the chunk's top bit recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin    = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
  assign last_chunk = (idx == LAST_IDX);

  // Partial result fills from the top; after NCH shifts chunk 0 sits at the LSB.
  generate
    if (NCH > 1) begin : g_multi
      assign partial_next = {chunk_sum, partial[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign partial_next = chunk_sum;
    end
  endgenerate

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      partial  <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Subtraction is a + ~b + ~borrow, so invert b and the carry at capture.
          if (start) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{mode}};
            carry <= carryIn ^ mode;
            idx   <= '0;
          end
        end
        RUN: begin
          partial <= partial_next;
          carry   <= chunk_cout;
          idx     <= idx + 1'b1;
          if (last_chunk) begin
            sum      <= partial_next;
            carryOut <= chunk_cout;
            overflow <= msb_cin ^ chunk_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 16/4 instance with a result scoreboard,
// plus an 8/8 instance for the single-chunk protocol.
module tb_seq_chunk_adder;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } result_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  logic         start8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic         busy8;
  logic         done8;
  logic [7:0]   sum8;
  logic         carry_out8;
  logic         overflow8;

  result_t      exp_q[$];
  logic [W-1:0] held_sum;
  int           compared = 0;
  int           mismatched = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
    .carryIn(carry_in), .busy(busy), .done(done), .sum(sum),
    .carryOut(carry_out), .overflow(overflow)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(1'b0), .a(a8), .b(b8),
    .carryIn(1'b0), .busy(busy8), .done(done8), .sum(sum8),
    .carryOut(carry_out8), .overflow(overflow8)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: signed overflow when both addends share a sign the result lacks.
  function automatic result_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                    input logic mm, input logic mc);
    result_t      r;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx     = mm ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mc ^ mm};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ma[W-1] == bx[W-1]) && (full[W-1] != ma[W-1]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                input logic tm, input logic tc, input result_t r);
    a        = ta;
    b        = tb_v;
    mode     = tm;
    carry_in = tc;
    start    = 1'b1;
    exp_q.push_back(r);
    tick();
    start = 1'b0;
    check_output("accept_busy", {31'b0, busy}, 32'd1);
  endtask

  // Waits (bounded) for done, checks latency, busy length, held outputs, then the result.
  task automatic wait_result(input string tag, input int latency);
    int      edges = 0;
    int      busy_cycles = 0;
    logic    leak = 1'b0;
    result_t r;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      if (sum !== held_sum) leak = 1'b1;
      tick();
      edges++;
    end
    check_output({tag, "_done"}, {31'b0, done}, 32'd1);
    check_output({tag, "_latency"}, edges, latency);
    check_output({tag, "_busy_len"}, busy_cycles, latency);
    check_output({tag, "_no_partial"}, {31'b0, leak}, 32'd0);
    check_output({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check_output({tag, "_queue"}, exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check_output({tag, "_sum"}, {16'b0, sum}, {16'b0, r.sum});
      check_output({tag, "_cout"}, {31'b0, carry_out}, {31'b0, r.cout});
      check_output({tag, "_ovf"}, {31'b0, overflow}, {31'b0, r.ovf});
      held_sum = r.sum;
    end
    tick();
    check_output({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    check_output({tag, "_sum_held"}, {16'b0, sum}, {16'b0, held_sum});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    result_t r;
    int      extra_done;
    int      extra_busy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    start8   = 1'b0;
    a8       = '0;
    b8       = '0;
    held_sum = '0;
    tick();
    tick();
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_done", {31'b0, done}, 32'd0);
    check_output("rst_sum", {16'b0, sum}, 32'd0);
    check_output("rst_cout", {31'b0, carry_out}, 32'd0);
    check_output("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    r = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, r);
    wait_result("add_ffff_1", N);

    r = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, r);
    wait_result("add_7fff_1", N);

    r = '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
    apply_stimulus(16'h8000, 16'h0001, 1'b1, 1'b0, r);
    wait_result("sub_8000_1", N);

    r = '{sum: 16'hFFFF, cout: 1'b0, ovf: 1'b0};
    apply_stimulus(16'h0000, 16'h0001, 1'b1, 1'b0, r);
    wait_result("sub_0_1", N);

    r = '{sum: 16'h1236, cout: 1'b0, ovf: 1'b0};
    apply_stimulus(16'h1234, 16'h0001, 1'b0, 1'b1, r);
    wait_result("add_cin", N);

    r = '{sum: 16'h1232, cout: 1'b1, ovf: 1'b0};
    apply_stimulus(16'h1234, 16'h0001, 1'b1, 1'b1, r);
    wait_result("sub_bin", N);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      r  = model(ra, rb, i[0], i[1]);
      apply_stimulus(ra, rb, i[0], i[1], r);
      wait_result("rand_op", N);
    end

    // Operands and start disturbed mid-RUN must not affect the captured operation.
    r = '{sum: 16'h2468, cout: 1'b0, ovf: 1'b0};
    apply_stimulus(16'h1234, 16'h1234, 1'b0, 1'b0, r);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("midrun", N - 1);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) extra_done++;
      if (busy) extra_busy++;
      tick();
    end
    check_output("midrun_extra_done", extra_done, 0);
    check_output("midrun_extra_busy", extra_busy, 0);

    // Continuous start: two operations back to back, NCH+2 cycles apart.
    r = '{sum: 16'h0303, cout: 1'b0, ovf: 1'b0};
    a        = 16'h0102;
    b        = 16'h0201;
    mode     = 1'b0;
    carry_in = 1'b0;
    start    = 1'b1;
    exp_q.push_back(r);
    exp_q.push_back(r);
    tick();
    check_output("b2b_accept1", {31'b0, busy}, 32'd1);
    wait_result("b2b_first", N);
    tick();
    start = 1'b0;
    check_output("b2b_accept2", {31'b0, busy}, 32'd1);
    wait_result("b2b_second", N);

    // Reset mid-RUN abandons the operation asynchronously.
    r = model(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    apply_stimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0, r);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_output("async_rst_busy", {31'b0, busy}, 32'd0);
    check_output("async_rst_done", {31'b0, done}, 32'd0);
    check_output("async_rst_sum", {16'b0, sum}, 32'd0);
    check_output("async_rst_cout", {31'b0, carry_out}, 32'd0);
    check_output("async_rst_ovf", {31'b0, overflow}, 32'd0);
    void'(exp_q.pop_back());
    held_sum = '0;
    #2;
    reset = 1'b0;
    tick();
    check_output("post_rst_done", {31'b0, done}, 32'd0);
    r = '{sum: 16'h2345, cout: 1'b0, ovf: 1'b0};
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0, r);
    wait_result("post_rst_add", N);

    // Single-chunk instance: done one edge after acceptance.
    a8     = 8'h80;
    b8     = 8'h80;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check_output("w8_busy", {31'b0, busy8}, 32'd1);
    check_output("w8_done_early", {31'b0, done8}, 32'd0);
    tick();
    check_output("w8_done", {31'b0, done8}, 32'd1);
    check_output("w8_busy_off", {31'b0, busy8}, 32'd0);
    check_output("w8_sum", {24'b0, sum8}, 32'h00);
    check_output("w8_cout", {31'b0, carry_out8}, 32'd1);
    check_output("w8_ovf", {31'b0, overflow8}, 32'd1);
    tick();
    check_output("w8_done_1cyc", {31'b0, done8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = add, 1 = subtract.
REQ-008 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-009 The block SHALL have port carryIn, input, 1 bit: carry-in when adding, borrow-in when subtracting.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have port carryOut, output, 1 bit: final carry out of the MSB.
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 FSM transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after NCH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 On a rising edge in IDLE with start=1, the block SHALL capture a, b^{WIDTH{mode}} and an initial carry of carryIn^mode, and SHALL clear the chunk index.
REQ-018 Arithmetic SHALL be: mode=0 gives a+b+carryIn; mode=1 gives a-b-carryIn, computed as a+~b+~carryIn.
REQ-019 Each RUN edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK, LSB chunk first) with the registered carry, store the partial sum, update the carry, and increment k.
REQ-020 On the edge that processes chunk NCH-1, the block SHALL load sum, carryOut and overflow together and enter DONE.
REQ-021 carryOut SHALL be the raw carry out of bit WIDTH-1 (for subtract, 1 means no borrow).
REQ-022 overflow SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 busy SHALL be 1 exactly while in RUN.
REQ-024 done SHALL be 1 exactly while in DONE, so it rises on edge S+NCH when the start is accepted on edge S.
REQ-025 sum, carryOut and overflow SHALL hold their value from completion until the next completion; partial results SHALL never appear on these outputs.
REQ-026 start SHALL be ignored in RUN and in DONE.
REQ-027 Changes to a, b, mode or carryIn after acceptance SHALL NOT affect the operation in progress.
REQ-028 A start asserted continuously SHALL be re-accepted on the first IDLE edge, giving back-to-back operations every NCH+2 cycles.
REQ-029 With CHUNK=WIDTH, the block SHALL have a single RUN cycle and otherwise identical protocol.

Reset
REQ-030 While reset=1, regardless of clk, the block SHALL force state to IDLE and drive busy=0, done=0, sum=0, carryOut=0, overflow=0, with the chunk index, carry and operand registers cleared.
REQ-031 Reset asserted mid-RUN SHALL abandon the operation with no done pulse, leaving outputs at their reset values.
REQ-032 After reset deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-033 The bench SHALL cover: add 0xFFFF+0x0001, cin=0 -> sum=0x0000, carryOut=1, overflow=0; done high on the 4th edge after acceptance, one cycle only; busy high for 4 cycles.
REQ-034 The bench SHALL cover: add 0x7FFF+0x0001, cin=0 -> sum=0x8000, carryOut=0, overflow=1.
REQ-035 The bench SHALL cover: sub 0x8000-0x0001, cin=0 -> sum=0x7FFF, carryOut=1, overflow=1; sub 0x0000-0x0001, cin=0 -> sum=0xFFFF, carryOut=0, overflow=0.
REQ-036 The bench SHALL cover: change a/b and pulse start during RUN -> no effect; result matches the captured operands; exactly one done pulse.
REQ-037 The bench SHALL cover: assert reset after 2 RUN cycles -> busy=0, done=0, sum=0 immediately (asynchronously); a subsequent 0x1234+0x1111 -> sum=0x2345.
REQ-038 The bench SHALL cover: WIDTH=8, CHUNK=8, 0x80+0x80 -> sum=0x00, carryOut=1, overflow=1; done 1 edge after acceptance.
